// File: rtl/gauss_noise_gen.sv
// Multi-channel Gaussian noise source: LFSR or external uniform
// input folded through a shared mirrored PWL inverse-CDF table.
module gauss_noise_gen #(
  parameter int          N_CH      = 2,
  parameter int          SEG_BITS  = 6,
  parameter int          OUT_WIDTH = 18,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      ext_mode,
  input  logic [N_CH*31-1:0]        in_,
  input  logic                      cfg_we,
  input  logic [SEG_BITS-1:0]       cfg_addr,
  input  logic [OUT_WIDTH-1:0]      cfg_offset,
  input  logic [OUT_WIDTH-1:0]      cfg_slope,
  output logic [N_CH*OUT_WIDTH-1:0] out,
  output logic                      out_valid
);

  localparam int NSEG = 1 << SEG_BITS;
  localparam int PW   = OUT_WIDTH + 16;
  localparam int LOW  = 14 - SEG_BITS;
  localparam logic [OUT_WIDTH:0] MAXV =
    {2'b00, {(OUT_WIDTH-1){1'b1}}};

  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] t;
    t = SEED ^ (32'(c + 1) * 32'h9E3779B9);
    return (t == 32'h0) ? 32'h1 : t;
  endfunction

  // Galois form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  logic [31:0]          lfsr_q  [N_CH];
  logic [OUT_WIDTH-1:0] off_q   [NSEG];
  logic [OUT_WIDTH-1:0] slp_q   [NSEG];

  logic                 s1_q    [N_CH];
  logic [SEG_BITS-1:0]  idx1_q  [N_CH];
  logic [15:0]          frac1_q [N_CH];
  logic                 s2_q    [N_CH];
  logic [OUT_WIDTH-1:0] off2_q  [N_CH];
  logic [OUT_WIDTH-1:0] prod2_q [N_CH];
  logic [OUT_WIDTH-1:0] out_q   [N_CH];
  logic                 v1_q, v2_q, v3_q;

  logic [30:0]          u_w     [N_CH];
  logic [29:0]          d_w     [N_CH];
  logic [PW-1:0]        prod_w  [N_CH];
  logic [OUT_WIDTH:0]   sum_w   [N_CH];
  logic [OUT_WIDTH-1:0] m_w     [N_CH];
  logic [OUT_WIDTH-1:0] res_w   [N_CH];
  logic [N_CH-1:0]      unused_lo;

  always_comb begin
    unused_lo = '0;
    for (int c = 0; c < N_CH; c++) begin
      u_w[c] = ext_mode ? in_[31*c +: 31] : lfsr_q[c][30:0];
      d_w[c] = u_w[c][30] ? u_w[c][29:0] : ~u_w[c][29:0];
      prod_w[c] = PW'(slp_q[idx1_q[c]]) * PW'(frac1_q[c]);
      sum_w[c] = {1'b0, off2_q[c]} + {1'b0, prod2_q[c]};
      m_w[c] = (sum_w[c] > MAXV) ? MAXV[OUT_WIDTH-1:0]
                                 : sum_w[c][OUT_WIDTH-1:0];
      res_w[c] = s2_q[c] ? m_w[c] : -m_w[c];
      unused_lo[c] = ^{d_w[c][LOW-1:0], prod_w[c][15:0]};
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (rst)     lfsr_q[c] <= seed_of(c);
      else if (en) lfsr_q[c] <= step(lfsr_q[c]);
    end
  end

  // Reads during a write to the same entry see the old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        off_q[i] <= '0;
        slp_q[i] <= '0;
      end
    end else if (cfg_we) begin
      off_q[cfg_addr] <= cfg_offset;
      slp_q[cfg_addr] <= cfg_slope;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) out_q[c] <= '0;
    end else begin
      v1_q <= en;
      v2_q <= v1_q;
      v3_q <= v2_q;
      for (int c = 0; c < N_CH; c++) begin
        if (en) begin
          s1_q[c]    <= u_w[c][30];
          idx1_q[c]  <= d_w[c][29 -: SEG_BITS];
          frac1_q[c] <= d_w[c][LOW +: 16];
        end
        if (v1_q) begin
          s2_q[c]    <= s1_q[c];
          off2_q[c]  <= off_q[idx1_q[c]];
          prod2_q[c] <= prod_w[c][PW-1:16];
        end
        if (v2_q) out_q[c] <= res_w[c];
      end
    end
  end

  always_comb begin
    out = '0;
    for (int c = 0; c < N_CH; c++)
      out[OUT_WIDTH*c +: OUT_WIDTH] = out_q[c];
  end

  assign out_valid = v3_q;

endmodule
